// File: rtl/line_buffer_scheduler_pkg.sv
// Shared constants, FSM encoding and enable-mask helpers
// for the line buffer scheduler.
package line_buffer_scheduler_pkg;

  localparam int NUM_LB     = 4;
  localparam int READ_LINES = 3;
  localparam int SEL_W      = $clog2(NUM_LB);

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  function automatic logic [NUM_LB-1:0] onehot(
    input logic [SEL_W-1:0] sel
  );
    return NUM_LB'(1) << sel;
  endfunction

  // Bits base..base+READ_LINES-1, wrapping around the ring.
  function automatic logic [NUM_LB-1:0] rd_mask(
    input logic [SEL_W-1:0] base
  );
    logic [NUM_LB-1:0] m;
    m = '0;
    for (int i = 0; i < READ_LINES; i++) begin
      m[base + SEL_W'(i)] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/line_buffer_scheduler.sv
// Ring scheduler over four external line buffers: one is
// written while three complete lines are read as a window.
module line_buffer_scheduler
  import line_buffer_scheduler_pkg::*;
#(
  parameter int LINE_WIDTH = 512,
  parameter int ADDR_W     = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pixel_valid,
  output logic              in_ready,
  output logic [NUM_LB-1:0] lb_wr_en,
  output logic [ADDR_W-1:0] lb_wr_addr,
  input  logic              rd_ready,
  output logic              window_valid,
  output logic [NUM_LB-1:0] lb_rd_en,
  output logic [ADDR_W-1:0] lb_rd_addr,
  output logic              line_done
);

  localparam int OCC_W = $clog2(NUM_LB * LINE_WIDTH + 1);

  localparam logic [OCC_W-1:0] OCC_MAX =
    OCC_W'(NUM_LB * LINE_WIDTH);
  localparam logic [OCC_W-1:0] OCC_RD =
    OCC_W'(READ_LINES * LINE_WIDTH);
  localparam logic [OCC_W-1:0] OCC_LINE =
    OCC_W'(LINE_WIDTH);
  localparam logic [ADDR_W-1:0] LAST_COL =
    ADDR_W'(LINE_WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [SEL_W-1:0] wr_sel;
  logic [SEL_W-1:0] rd_base;
  logic [OCC_W-1:0] occupancy;
  logic [OCC_W-1:0] occ_nxt;
  logic             wr_fire;
  logic             rd_fire;
  logic             wr_last;
  logic             rd_last;

  always_comb begin
    in_ready     = occupancy < OCC_MAX;
    wr_fire      = pixel_valid & in_ready;
    window_valid = state == READ;
    rd_fire      = window_valid & rd_ready;
    wr_last      = lb_wr_addr == LAST_COL;
    rd_last      = rd_fire && (lb_rd_addr == LAST_COL);
    lb_wr_en     = wr_fire ? onehot(wr_sel) : '0;
    lb_rd_en     = rd_fire ? rd_mask(rd_base) : '0;
  end

  // Write and line retire may coincide: net +1-LINE_WIDTH.
  always_comb begin
    occ_nxt = occupancy;
    if (wr_fire) begin
      occ_nxt = occ_nxt + OCC_W'(1);
    end
    if (rd_last) begin
      occ_nxt = occ_nxt - OCC_LINE;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (occupancy >= OCC_RD) begin
          state_nxt = READ;
        end
      end
      READ: begin
        if (rd_last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_sel     <= '0;
      lb_wr_addr <= '0;
    end else if (wr_fire) begin
      if (wr_last) begin
        lb_wr_addr <= '0;
        wr_sel     <= wr_sel + SEL_W'(1);
      end else begin
        lb_wr_addr <= lb_wr_addr + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_base    <= '0;
      lb_rd_addr <= '0;
    end else if (rd_fire) begin
      if (rd_last) begin
        lb_rd_addr <= '0;
        rd_base    <= rd_base + SEL_W'(1);
      end else begin
        lb_rd_addr <= lb_rd_addr + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occupancy <= '0;
      line_done <= 1'b0;
    end else begin
      occupancy <= occ_nxt;
      line_done <= rd_last;
    end
  end

endmodule

// File: doc/line_buffer_scheduler.md
LINE_BUFFER_SCHEDULER -- requirements
Module: line_buffer_scheduler

Interface
REQ-001 Parameter LINE_WIDTH, default 512, pixels per line buffer; legal range 2..4096.
REQ-002 Parameter ADDR_W, default 9, line address width; SHALL equal clog2(LINE_WIDTH).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 pixel_valid  input  1  upstream presents a pixel this cycle.
REQ-006 in_ready  output  1  scheduler can accept a pixel; a pixel is written only when pixel_valid and in_ready are both high.
REQ-007 lb_wr_en  output  4  one-hot write enable to line buffers 0..3.
REQ-008 lb_wr_addr  output  ADDR_W  next location to write in the selected buffer.
REQ-009 rd_ready  input  1  downstream window consumer accepts a column this cycle.
REQ-010 window_valid  output  1  three full lines are available and a column is being presented.
REQ-011 lb_rd_en  output  4  read enables; exactly three bits set during a read handshake, else zero.
REQ-012 lb_rd_addr  output  ADDR_W  next column to read, common to the three read buffers.
REQ-013 line_done  output  1  one-cycle pulse after the oldest line has been fully consumed.

Function
REQ-014 Write side: wr_sel (2 bits) and lb_wr_addr SHALL advance on each accepted pixel; at lb_wr_addr = LINE_WIDTH-1, lb_wr_addr wraps to 0 and wr_sel increments modulo 4.
REQ-015 lb_wr_en SHALL be combinational: one-hot(wr_sel) when pixel_valid and in_ready, else 4'b0000.
REQ-016 occupancy register, width clog2(4*LINE_WIDTH+1), SHALL count buffered pixels: +1 per accepted write, -LINE_WIDTH per completed line, both in the same cycle giving +1-LINE_WIDTH.
REQ-017 in_ready SHALL be high iff occupancy < 4*LINE_WIDTH; pixels offered while in_ready is low are dropped with no state change.
REQ-018 FSM states IDLE and READ; IDLE->READ when registered occupancy >= 3*LINE_WIDTH; READ->IDLE on the handshake of column LINE_WIDTH-1.
REQ-019 window_valid SHALL equal (state == READ).
REQ-020 lb_rd_en SHALL set bits rd_base, rd_base+1, rd_base+2 (mod 4) when window_valid and rd_ready, else zero.
REQ-021 lb_rd_addr SHALL increment on each read handshake; on the handshake at LINE_WIDTH-1 it wraps to 0, rd_base increments modulo 4 and occupancy drops by LINE_WIDTH.
REQ-022 line_done SHALL be a registered pulse, high for exactly the cycle after the final-column handshake.
REQ-023 rd_ready low in READ SHALL hold lb_rd_addr, rd_base and state unchanged.
REQ-024 Occupancy SHALL never exceed 4*LINE_WIDTH nor underflow; writes never target a buffer currently being read.

Reset
REQ-025 On rst: state IDLE, wr_sel 0, rd_base 0, lb_wr_addr 0, lb_rd_addr 0, occupancy 0, line_done 0; hence in_ready 1, window_valid 0, lb_wr_en 0, lb_rd_en 0.
REQ-026 rst asserted mid-operation SHALL discard all buffered lines immediately; the buffer memory contents themselves are not cleared.

Structure
REQ-027 NUM_LB = 4 and READ_LINES = 3 constants and the FSM state encoding SHALL live in a shared package used by the datapath blocks.
REQ-028 The block is a single module; the line buffer memories themselves are external and not instantiated here.

Verification (LINE_WIDTH=4, ADDR_W=2)
REQ-029 Reset held then released with no input -> in_ready=1, window_valid=0, all enables 0, occupancy 0.
REQ-030 12 consecutive pixels, rd_ready=0 -> lb_wr_en 0001 x4, 0010 x4, 0100 x4, lb_wr_addr 0,1,2,3 per buffer; window_valid rises one clock after occupancy reaches 12.
REQ-031 16 pixels then 2 more, rd_ready=0 -> in_ready low after 16th, extra pixels produce no lb_wr_en, occupancy stays 16.
REQ-032 From 12 buffered, rd_ready=1 -> lb_rd_en 0111 with lb_rd_addr 0..3, line_done pulses once the cycle after, next window uses lb_rd_en 1110, occupancy 8.
REQ-033 Occupancy 15, write coinciding with final-column handshake -> occupancy 12, window_valid returns high one clock after dropping.
REQ-034 Continuous streaming until rd_base=3 -> lb_rd_en 1011, wr_sel wraps 3->0; rst pulsed mid-read -> all outputs return to REQ-025 values within the same cycle.
